score_board_bcd: RTL and testbench

SCORE_BOARD_BCD -- requirements
Module: score_board_bcd

---
 rtl/score_board_bcd.sv | 136 +++++++++++++
 tb/tb_score_board_bcd.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/score_board_bcd.sv
// score_board_bcd: two-player BCD goal counter with optional win detection.
//   clk       : single clock, all state changes on the rising edge
//   rst       : asynchronous active-low reset
//   enable    : 1 = play, 0 = clear scores and return to IDLE at the next edge
//   goal0/1   : goal levels; each rising edge is one point
//   score0/1  : BCD scores, least-significant digit at [3:0]
//   winner    : 00 none, 01 player 0, 10 player 1, 11 tie
//   game_over : high while in WIN
//   win_pulse : one-cycle strobe on entry to WIN

// One BCD digit of a ripple incrementer.
module bcd_digit_inc (
  input  logic [3:0] d,
  input  logic       cin,
  output logic [3:0] q,
  output logic       cout
);
  assign cout = cin & (d == 4'd9);
  assign q    = !cin ? d : ((d == 4'd9) ? 4'd0 : d + 4'd1);
endmodule

// Multi-digit BCD incrementer that saturates at all nines.
module bcd_inc #(
  parameter int DIGITS = 2
) (
  input  logic [4*DIGITS-1:0] val,
  input  logic                inc,
  output logic [4*DIGITS-1:0] nxt
);
  logic [DIGITS:0]     carry;
  logic [4*DIGITS-1:0] rip;

  assign carry[0] = inc;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit_inc u_dig (
      .d   (val[4*g +: 4]),
      .cin (carry[g]),
      .q   (rip[4*g +: 4]),
      .cout(carry[g+1])
    );
  end

  // A carry out of the top digit means every digit was 9: hold instead of wrapping.
  assign nxt = carry[DIGITS] ? val : rip;
endmodule

module score_board_bcd #(
  parameter int                  DIGITS     = 2,
  parameter logic [4*DIGITS-1:0] WIN_BCD    = (4*DIGITS)'(7),
  parameter int                  WIN_ENABLE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                goal0,
  input  logic                goal1,
  output logic [4*DIGITS-1:0] score0,
  output logic [4*DIGITS-1:0] score1,
  output logic [1:0]          winner,
  output logic                game_over,
  output logic                win_pulse
);
  typedef enum logic [1:0] {IDLE, PLAY, WIN} state_t;

  state_t              state, state_nxt;
  logic                goal0_d, goal1_d;
  logic                ev0, ev1, hit0, hit1;
  logic [4*DIGITS-1:0] inc0, inc1;
  logic [4*DIGITS-1:0] score0_nxt, score1_nxt;
  logic [1:0]          winner_nxt;
  logic                pulse_nxt;

  // goal_d resets high so a goal already asserted at reset release is not a point.
  assign ev0 = goal0 & ~goal0_d;
  assign ev1 = goal1 & ~goal1_d;

  bcd_inc #(.DIGITS(DIGITS)) u_inc0 (.val(score0), .inc(ev0), .nxt(inc0));
  bcd_inc #(.DIGITS(DIGITS)) u_inc1 (.val(score1), .inc(ev1), .nxt(inc1));

  // Win only on a fresh point whose post-increment value hits the target.
  assign hit0 = (WIN_ENABLE != 0) && ev0 && (inc0 == WIN_BCD);
  assign hit1 = (WIN_ENABLE != 0) && ev1 && (inc1 == WIN_BCD);

  assign game_over = (state == WIN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      goal0_d   <= 1'b1;
      goal1_d   <= 1'b1;
      score0    <= '0;
      score1    <= '0;
      winner    <= 2'b00;
      win_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      goal0_d   <= goal0;
      goal1_d   <= goal1;
      score0    <= score0_nxt;
      score1    <= score1_nxt;
      winner    <= winner_nxt;
      win_pulse <= pulse_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    score0_nxt = score0;
    score1_nxt = score1;
    winner_nxt = winner;
    pulse_nxt  = 1'b0;
    if (!enable) begin
      // Clear has priority over any point event in the same cycle.
      state_nxt  = IDLE;
      score0_nxt = '0;
      score1_nxt = '0;
      winner_nxt = 2'b00;
    end else begin
      case (state)
        IDLE: state_nxt = PLAY;
        PLAY: begin
          score0_nxt = inc0;
          score1_nxt = inc1;
          if (hit0 || hit1) begin
            state_nxt  = WIN;
            winner_nxt = {hit1, hit0};
            pulse_nxt  = 1'b1;
          end
        end
        WIN:     ;
        default: state_nxt = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_score_board_bcd.sv
module tb_score_board_bcd;
  logic       clk = 1'b0;
  logic       rst, enable, goal0, goal1;
  logic [7:0] a_s0, a_s1, b_s0, b_s1;
  logic [1:0] a_win, b_win;
  logic       a_go, b_go, a_wp, b_wp;

  int  errors = 0;
  int  checks = 0;
  bit  chk_on = 1'b0;

  always #5 clk = ~clk;

  // a: win detection at 07; b: free-running with saturation
  score_board_bcd #(.DIGITS(2), .WIN_BCD(8'h07), .WIN_ENABLE(1)) ua (
    .clk(clk), .rst(rst), .enable(enable), .goal0(goal0), .goal1(goal1),
    .score0(a_s0), .score1(a_s1), .winner(a_win), .game_over(a_go), .win_pulse(a_wp));

  score_board_bcd #(.DIGITS(2), .WIN_BCD(8'h07), .WIN_ENABLE(0)) ub (
    .clk(clk), .rst(rst), .enable(enable), .goal0(goal0), .goal1(goal1),
    .score0(b_s0), .score1(b_s1), .winner(b_win), .game_over(b_go), .win_pulse(b_wp));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int bcd(input int v);
    return ((v / 10) << 4) | (v % 10);
  endfunction

  // Reference model: decimal scores, state as 0 idle / 1 play / 2 won.
  int       ms0 [2];
  int       ms1 [2];
  int       mst [2];
  bit [1:0] mw  [2];
  bit       mp  [2];
  bit       g0d, g1d;
  localparam int WIN_EN [2] = '{1, 0};

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        ms0[k] <= 0; ms1[k] <= 0; mst[k] <= 0; mw[k] <= 2'b00; mp[k] <= 1'b0;
      end
      g0d <= 1'b1;
      g1d <= 1'b1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit e0, e1, h0, h1;
        int n0, n1;
        e0 = goal0 && !g0d;
        e1 = goal1 && !g1d;
        n0 = e0 ? ((ms0[k] + 1 > 99) ? 99 : ms0[k] + 1) : ms0[k];
        n1 = e1 ? ((ms1[k] + 1 > 99) ? 99 : ms1[k] + 1) : ms1[k];
        h0 = WIN_EN[k] != 0 && e0 && n0 == 7;
        h1 = WIN_EN[k] != 0 && e1 && n1 == 7;
        mp[k] <= 1'b0;
        if (!enable) begin
          ms0[k] <= 0; ms1[k] <= 0; mw[k] <= 2'b00; mst[k] <= 0;
        end else if (mst[k] == 0) begin
          mst[k] <= 1;
        end else if (mst[k] == 1) begin
          ms0[k] <= n0;
          ms1[k] <= n1;
          if (h0 || h1) begin
            mst[k] <= 2; mw[k] <= {h1, h0}; mp[k] <= 1'b1;
          end
        end
      end
      g0d <= goal0;
      g1d <= goal1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("a_score0", a_s0, bcd(ms0[0]));
      chk("a_score1", a_s1, bcd(ms1[0]));
      chk("a_winner", a_win, mw[0]);
      chk("a_game_over", a_go, int'(mst[0] == 2));
      chk("a_win_pulse", a_wp, mp[0]);
      chk("b_score0", b_s0, bcd(ms0[1]));
      chk("b_score1", b_s1, bcd(ms1[1]));
      chk("b_winner", b_win, mw[1]);
      chk("b_game_over", b_go, int'(mst[1] == 2));
      chk("b_win_pulse", b_wp, mp[1]);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse0();
    goal0 = 1'b1; tick(1); goal0 = 1'b0; tick(1);
  endtask

  task automatic pulse1();
    goal1 = 1'b1; tick(1); goal1 = 1'b0; tick(1);
  endtask

  task automatic restart();
    enable = 1'b0; tick(1); enable = 1'b1; tick(1);
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; goal0 = 1'b0; goal1 = 1'b0;
    tick(2);
    chk_on = 1'b1;
    chk("rst_a_score0", a_s0, 8'h00);
    chk("rst_a_winner", a_win, 2'b00);
    chk("rst_a_game_over", a_go, 0);
    chk("rst_b_win_pulse", b_wp, 0);
    rst = 1'b1;
    tick(1);
    enable = 1'b1;
    tick(1);

    // Saturation on the free-running board; win at 7 on the other.
    repeat (99) pulse0();
    chk("sat_b_score0_99", b_s0, 8'h99);
    chk("sat_b_score1_00", b_s1, 8'h00);
    pulse0();
    chk("sat_b_score0_hold", b_s0, 8'h99);
    chk("win_a_score0", a_s0, 8'h07);
    chk("win_a_winner", a_win, 2'b01);
    chk("win_a_game_over", a_go, 1);

    // BCD carry 09 -> 10, and a held goal scores only once.
    restart();
    repeat (9) pulse0();
    chk("carry_b_09", b_s0, 8'h09);
    goal0 = 1'b1;
    tick(1);
    chk("carry_b_10", b_s0, 8'h10);
    tick(4);
    chk("held_b_10", b_s0, 8'h10);
    goal0 = 1'b0;
    tick(1);

    // Tie: both reach 7 on the same edge.
    restart();
    repeat (6) pulse0();
    repeat (6) pulse1();
    chk("tie_pre_a_go", a_go, 0);
    goal0 = 1'b1; goal1 = 1'b1;
    tick(1);
    chk("tie_a_score0", a_s0, 8'h07);
    chk("tie_a_score1", a_s1, 8'h07);
    chk("tie_a_winner", a_win, 2'b11);
    chk("tie_a_win_pulse", a_wp, 1);
    chk("tie_b_winner", b_win, 2'b00);
    goal0 = 1'b0; goal1 = 1'b0;
    tick(1);
    chk("tie_a_pulse_once", a_wp, 0);
    chk("tie_a_game_over", a_go, 1);

    // Frozen in WIN, then clear and resume play.
    pulse0(); pulse1();
    chk("frozen_a_score0", a_s0, 8'h07);
    chk("frozen_a_score1", a_s1, 8'h07);
    enable = 1'b0;
    tick(1);
    chk("clr_a_score0", a_s0, 8'h00);
    chk("clr_a_winner", a_win, 2'b00);
    chk("clr_a_game_over", a_go, 0);
    enable = 1'b1;
    tick(1);
    pulse0();
    chk("replay_a_score0", a_s0, 8'h01);

    // Clear beats a simultaneous point.
    pulse1(); pulse1();
    chk("pre_clr_a_score1", a_s1, 8'h02);
    goal1 = 1'b1; enable = 1'b0;
    tick(1);
    chk("clr_prio_a_score1", a_s1, 8'h00);
    goal1 = 1'b0; enable = 1'b1;
    tick(2);

    // Async reset mid-game with goal0 held high.
    pulse0(); pulse0();
    chk("pre_rst_a_score0", a_s0, 8'h02);
    goal0 = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("arst_a_score0", a_s0, 8'h00);
    chk("arst_b_score0", b_s0, 8'h00);
    chk("arst_a_winner", a_win, 2'b00);
    chk("arst_a_go", a_go, 0);
    tick(1);
    rst = 1'b1;
    tick(4);
    chk("no_pt_after_rst", a_s0, 8'h00);
    goal0 = 1'b0;
    tick(1);
    pulse0();
    chk("pt_after_rst", a_s0, 8'h01);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
